xor_frame_accum: RTL and testbench
==================================

// Module: xor_frame_accum
// PURPOSE
//   Parametrised successor to the 2-input XOR gate: folds a stream of WIDTH-bit words
//   into one WIDTH-bit XOR (or XNOR) signature per frame.
//   Uses valid/ready handshakes on input and output.
//   Sits between a word source and a checker/consumer as a per-frame checksum/parity stage.
// PARAMETERS
//   WIDTH  8    data word width in bits (>=1)
//   CNT_W  8    width of the per-frame beat counter (>=1)
//   INIT   0    WIDTH-bit seed the first beat of every frame is combined with
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   mode       in   1        0 = XOR, 1 = XNOR; sampled only on a frame's first accepted beat
//   in_valid   in   1        input word present
//   in_ready   out  1        block can accept a word
//   in_data    in   WIDTH    input word
//   in_last    in   1        qualifies the final word of a frame
//   out_valid  out  1        frame result present
//   out_ready  in   1        consumer accepts the result
//   out_data   out  WIDTH    frame signature
//   out_count  out  CNT_W    number of beats in the frame (saturating)
//   out_ovf    out  1        beat count exceeded 2^CNT_W-1
//   out_parity out  1        ^out_data (only with XOR_PARITY_EN)
// BEHAVIOUR
//   - Beat accepted when in_valid & in_ready. Result handed off when out_valid & out_ready.
//   - f(a,d) = a ^ d when mode_q=0; f(a,d) = ~(a ^ d) when mode_q=1.
//   - States:
//     IDLE:  in_ready=1. On a beat: acc<=f(INIT,in_data), count<=1, ovf<=0, mode_q<=mode.
//            Go to DONE if in_last, else go to ACCUM.
//     ACCUM: in_ready=1. On a beat: acc<=f(acc,in_data).
//            count increments; at 2^CNT_W-1 it holds and sets ovf (sticky for the frame).
//            Go to DONE if in_last. No beat: hold everything.
//     DONE:  in_ready=0, out_valid=1. out_data/out_count/out_ovf are stable until handshake.
//            On handshake go to IDLE.
//   - Latency: out_valid rises the cycle after the in_last beat is accepted.
//     One bubble cycle per frame (no DONE->accept bypass).
//   - mode changes mid-frame are ignored until the next frame's first beat.
//   - Reset while asserted, and the cycle it takes effect:
//     state=IDLE, acc=INIT, count=0, ovf=0, mode_q=0.
//     out_valid=0, out_data=INIT, out_count=0, out_ovf=0, in_ready=0.
//     in_ready is forced 0 while reset=1.
//   - Reset mid-frame discards the partial frame; no result is emitted for it.
//   - Reset in DONE drops the pending result.
//   - in_valid with in_last=1 in IDLE is a legal single-beat frame.
//   - All outputs are registered except in_ready, which is decoded from state and reset.
// CONFIGURATION
//   XOR_PARITY_EN defined: adds port out_parity = ^out_data.
//     Registered alongside out_data; reset value 0; stable in DONE.
//   XOR_PARITY_EN undefined: port and register are absent; all other behaviour is identical.
// STRUCTURE
//   Package xor_accum_pkg:
//     state_t enum {IDLE, ACCUM, DONE};
//     MODE_XOR=1'b0, MODE_XNOR=1'b1.
//   Sub-module xor_word #(WIDTH) (output y, input a, d, mode):
//     combinational f(a,d); one instance feeds the accumulator next-state logic.
//   Top level holds the FSM, the accumulator, the saturating counter and the output registers.
// TESTING
//   1. XOR, INIT=0: beats 0x0F, 0xF0, 0xFF(last) -> out_data=0x00, out_count=3, out_ovf=0.
//   2. XNOR, INIT=0: single beat 0xA5 with last -> out_data=0x5A, out_count=1,
//      out_valid exactly 1 cycle after the beat.
//   3. Backpressure: hold out_ready=0 for 5 cycles after DONE.
//      -> out_valid=1 throughout, outputs stable, in_ready=0, no beats consumed.
//   4. CNT_W=2: 5-beat frame of 0x01 -> out_count=3, out_ovf=1, out_data=0x01.
//   5. Reset asserted after 2 beats of a frame, then frame 0x33(last).
//      -> out_data=0x33, out_count=1; nothing emitted for the aborted frame.
//   6. XOR_PARITY_EN: frame yielding out_data=0x07 -> out_parity=1;
//      frame yielding 0x03 -> out_parity=0.

Source files
------------

// File: rtl/xor_accum_pkg.sv
// rtl/xor_accum_pkg.sv - shared state encoding and mode constants for the XOR frame accumulator
package xor_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_XOR  = 1'b0;
    localparam logic MODE_XNOR = 1'b1;

endpackage

// File: rtl/xor_frame_accum_if.sv
// rtl/xor_frame_accum_if.sv - word-in / signature-out handshake bundle; out_parity only with XOR_PARITY_EN
interface xor_frame_accum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
`ifdef XOR_PARITY_EN
    logic             out_parity;

    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf, out_parity
    );
    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf, out_parity
    );
`else
    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );
    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
`endif
endinterface

// File: rtl/xor_word.sv
// rtl/xor_word.sv - combinational word combine: a^d for XOR mode, ~(a^d) for XNOR mode
module xor_word
    import xor_accum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] d,
    input  logic             mode
);

    always_comb begin
        y = (mode == MODE_XNOR) ? ~(a ^ d) : (a ^ d);
    end

endmodule

// File: rtl/xor_frame_accum.sv
// rtl/xor_frame_accum.sv - folds each input frame into one XOR/XNOR signature; XOR_PARITY_EN adds out_parity
module xor_frame_accum
    import xor_accum_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input logic              clk,
    input logic              reset,
    xor_frame_accum_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] word_a, word_y;
    logic             word_mode;
    logic             beat;

    assign bus.in_ready = ~reset && (state_q != DONE);
    assign beat         = bus.in_valid && bus.in_ready;

    // The first beat of a frame combines with the seed under the mode presented with it.
    always_comb begin
        word_a    = (state_q == IDLE) ? INIT : acc_q;
        word_mode = (state_q == IDLE) ? bus.mode : mode_q;
    end

    xor_word #(.WIDTH(WIDTH)) u_xor_word (
        .y    (word_y),
        .a    (word_a),
        .d    (bus.in_data),
        .mode (word_mode)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = word_y;
                    count_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                    mode_d  = bus.mode;
                    state_d = bus.in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = word_y;
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (bus.in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= INIT;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            mode_q      <= MODE_XOR;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = ovf_q;

`ifdef XOR_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^acc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_xor_frame_accum.sv
// tb/tb_xor_frame_accum.sv - scoreboard bench for xor_frame_accum (CNT_W=2 so saturation is reachable)
module tb_xor_frame_accum;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = 2;
    localparam int         CMAX  = 3;
    localparam logic [7:0] INIT  = 8'h00;

    typedef struct {
        logic [7:0] data;
        int         count;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic force_low = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [7:0] frame_q[$];

    always #5 clk = ~clk;

    xor_frame_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    xor_frame_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W), .INIT(INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic m);
        exp_t       e;
        logic [7:0] a;
        a = INIT;
        foreach (frame_q[i]) a = m ? ~(a ^ frame_q[i]) : (a ^ frame_q[i]);
        e.data  = a;
        e.count = (frame_q.size() > CMAX) ? CMAX : frame_q.size();
        e.ovf   = (frame_q.size() > CMAX);
        return e;
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = force_low ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0h count %0d with no frame outstanding",
                         bus.out_data, bus.out_count);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_count", 32'(bus.out_count), 32'(e.count));
                check("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
`ifdef XOR_PARITY_EN
                check("out_parity", 32'(bus.out_parity), 32'(^e.data));
`endif
            end
        end
    end

    // Entry and exit at posedge+1. complete=0 sends frame_q without in_last (aborted frame).
    task automatic send_frame(input logic m, input bit gaps, input bit complete);
        int   t;
        logic accepted;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_data  = frame_q[i];
            bus.in_last  = complete && (i == frame_q.size() - 1);
            bus.mode     = (i == 0) ? m : 1'($urandom_range(1));
            bus.in_valid = 1'b1;
            t = 0;
            accepted = 1'b0;
            while (!accepted && t < 100) begin
                @(negedge clk);
                accepted = bus.in_ready;
                @(posedge clk);
                #1;
                t++;
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            if (!accepted) begin
                check("beat_accept_timeout", 32'(accepted), 32'd1);
                return;
            end
        end
        if (complete) begin
            exp_q.push_back(model(m));
            @(negedge clk);
            check("latency_out_valid", 32'(bus.out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (n) begin
            @(negedge clk);
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_out_data", 32'(bus.out_data), 32'(INIT));
            check("rst_out_count", 32'(bus.out_count), 32'd0);
            check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`ifdef XOR_PARITY_EN
            check("rst_out_parity", 32'(bus.out_parity), 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.mode     = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        frame_q = '{8'h0F, 8'hF0, 8'hFF};
        send_frame(1'b0, 1'b0, 1'b1);
        frame_q = '{8'hA5};
        send_frame(1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: result must sit untouched while a competing beat is offered.
        force_low = 1'b1;
        frame_q = '{8'h11, 8'h22};
        send_frame(1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_data", 32'(bus.out_data), 32'h33);
            check("bp_out_count", 32'(bus.out_count), 32'd2);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        force_low    = 1'b0;
        drain();

        frame_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        send_frame(1'b0, 1'b0, 1'b1);
        drain();

        frame_q = '{8'h5C, 8'h9E};
        send_frame(1'b0, 1'b0, 1'b0);
        do_reset(1);
        frame_q = '{8'h33};
        send_frame(1'b0, 1'b0, 1'b1);
        drain();

        frame_q = '{8'h07};
        send_frame(1'b0, 1'b0, 1'b1);
        frame_q = '{8'h03};
        send_frame(1'b0, 1'b0, 1'b1);
        drain();

        for (int f = 0; f < 150; f++) begin
            int n;
            n = $urandom_range(6, 1);
            frame_q.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
            send_frame(1'($urandom_range(1)), 1'b1, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
